// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: critical-word-first line refill with store merging during the fill
module cache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss,
    input  logic [ADDR_W-1:0]            miss_addr,
    output logic                         busy,
    output logic                         refill_valid,
    output logic [ADDR_W-1:0]            refill_addr,
    output logic [LINE_WORDS*WORD_W-1:0] refill_data,
    input  logic                         we,
    input  logic [WORD_W/8-1:0]          wvalid_bit,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [WORD_W-1:0]            wdata,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ack,
    input  logic [WORD_W-1:0]            mem_rdata
);
    localparam int BYTES = WORD_W / 8;
    localparam int BO_W  = $clog2(BYTES);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = BO_W + IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                         state;
    logic [ADDR_W-OFF_W-1:0]        tag;
    logic [IDX_W-1:0]               start, cnt, idx, st_idx;
    logic [LINE_WORDS*WORD_W-1:0]   line, line_nxt;
    logic [LINE_WORDS*BYTES-1:0]    mask, mask_nxt;
    logic                           st_hit, fill_ack, unused_ok;

    assign idx         = start + cnt;
    assign st_idx      = waddr[OFF_W-1:BO_W];
    assign st_hit      = we && state != IDLE && waddr[ADDR_W-1:OFF_W] == tag;
    assign fill_ack    = state == FILL && mem_ack;
    assign refill_data = state == DONE ? line_nxt : '0;
    assign unused_ok   = ^{waddr[BO_W-1:0], miss_addr[BO_W-1:0]};

    // Store bytes take priority; memory only fills bytes no store has claimed.
    always_comb begin
        line_nxt = line;
        mask_nxt = mask;
        for (int w = 0; w < LINE_WORDS; w++) begin
            for (int b = 0; b < BYTES; b++) begin
                if (st_hit && st_idx == IDX_W'(w) && wvalid_bit[b]) begin
                    line_nxt[w*WORD_W+b*8 +: 8] = wdata[b*8 +: 8];
                    mask_nxt[w*BYTES+b]         = 1'b1;
                end else if (fill_ack && idx == IDX_W'(w) && !mask[w*BYTES+b]) begin
                    line_nxt[w*WORD_W+b*8 +: 8] = mem_rdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            refill_valid <= 1'b0;
            refill_addr  <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            tag          <= '0;
            start        <= '0;
            cnt          <= '0;
            line         <= '0;
            mask         <= '0;
        end else begin
            line <= line_nxt;
            mask <= mask_nxt;
            case (state)
                IDLE: if (miss) begin
                    state    <= FILL;
                    busy     <= 1'b1;
                    mem_req  <= 1'b1;
                    mem_addr <= {miss_addr[ADDR_W-1:BO_W], {BO_W{1'b0}}};
                    tag      <= miss_addr[ADDR_W-1:OFF_W];
                    start    <= miss_addr[OFF_W-1:BO_W];
                    cnt      <= '0;
                    mask     <= '0;
                end
                FILL: if (mem_ack) begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state        <= DONE;
                        mem_req      <= 1'b0;
                        refill_valid <= 1'b1;
                        refill_addr  <= {tag, {OFF_W{1'b0}}};
                    end else begin
                        mem_addr <= {tag, idx + 1'b1, {BO_W{1'b0}}};
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    refill_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: scoreboard bench; expected fetch addresses and lines are queued
// when a miss is issued and popped as the DUT acknowledges fetches and delivers lines.
module tb_cache_refill_ctrl;
    logic         clk = 1'b0;
    logic         rst, miss, busy, refill_valid, we, mem_req, mem_ack;
    logic [31:0]  miss_addr, refill_addr, waddr, wdata, mem_addr, mem_rdata;
    logic [127:0] refill_data;
    logic [3:0]   wvalid_bit;

    logic [31:0]  exp_addr[$];
    logic [31:0]  exp_raddr[$];
    logic [127:0] exp_rdata[$];

    int n_checks = 0, n_fail = 0, cyc = 0, valid_count = 0, last_valid_cyc = 0;
    int ack_period = 1, ack_wait = 0, mem_mode = 0;
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr), .busy(busy),
        .refill_valid(refill_valid), .refill_addr(refill_addr), .refill_data(refill_data),
        .we(we), .wvalid_bit(wvalid_bit), .waddr(waddr), .wdata(wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic m, input logic [31:0] ma, input logic w,
                         input logic [3:0] bm, input logic [31:0] wa, input logic [31:0] wd);
        logic [31:0]  ea;
        logic [127:0] ed;
        @(negedge clk);
        cyc++;
        miss = m; miss_addr = ma; we = w; wvalid_bit = bm; waddr = wa; wdata = wd;
        mem_ack   = rst && mem_req && (ack_wait == ack_period - 1);
        mem_rdata = mem_mode != 0 ? 32'h1111_1111 : mem_addr;
        #1;
        if (prev_req && !prev_ack) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
                n_fail++;
                $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, prev_addr);
            end
        end
        if (mem_ack) begin
            n_checks++;
            if (exp_addr.size() == 0) begin
                n_fail++;
                $display("FAIL mem_addr: unexpected fetch of %h", mem_addr);
            end else begin
                ea = exp_addr.pop_front();
                if (mem_addr !== ea) begin
                    n_fail++;
                    $display("FAIL mem_addr: got %h, required %h", mem_addr, ea);
                end
            end
        end
        if (refill_valid) begin
            valid_count++;
            last_valid_cyc = cyc;
            n_checks++;
            if (exp_raddr.size() == 0) begin
                n_fail++;
                $display("FAIL refill_valid: unexpected pulse, addr %h", refill_addr);
            end else begin
                ea = exp_raddr.pop_front();
                ed = exp_rdata.pop_front();
                if (refill_addr !== ea || refill_data !== ed) begin
                    n_fail++;
                    $display("FAIL refill_line: got %h/%h, required %h/%h", refill_addr, refill_data, ea, ed);
                end
            end
        end
        ack_wait  = (rst && mem_req && !mem_ack) ? ack_wait + 1 : 0;
        prev_req  = mem_req && rst;
        prev_addr = mem_addr;
        prev_ack  = mem_ack;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic refill(input logic [31:0] ma, input int store_k, input logic [31:0] sa,
                          input logic [31:0] sd, input logic [3:0] sm, output int lat);
        int v0;
        v0  = valid_count;
        lat = -1;
        drive(1'b1, ma, 1'b0, 4'h0, 32'h0, 32'h0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_early: got %b, required 0", busy);
        end
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            drive(1'b0, ma, k == store_k, sm, sa, sd);
            if (k == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_rise: got %b, required 1", busy);
                end
            end
            if (valid_count != v0) lat = k;
        end
        n_checks++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL refill_timeout: no refill_valid for %h within 40 cycles, required one", ma);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        idle();
        n_checks++;
        if ({busy, refill_valid, mem_req} !== 3'b000 || refill_addr !== 0 || mem_addr !== 0 || refill_data !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b rv=%b req=%b ra=%h ma=%h rd=%h, required all 0",
                     busy, refill_valid, mem_req, refill_addr, mem_addr, refill_data);
        end
        rst = 1'b1;
        idle();
    endtask

    task automatic test_critical_word();
        int lat;
        ack_period = 1; mem_mode = 0;
        exp_addr.push_back(32'h1008); exp_addr.push_back(32'h100C);
        exp_addr.push_back(32'h1000); exp_addr.push_back(32'h1004);
        exp_raddr.push_back(32'h1000);
        exp_rdata.push_back({32'h100C, 32'h1008, 32'h1004, 32'h1000});
        refill(32'h1008, -1, 0, 0, 0, lat);
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL latency: refill_valid at cycle %0d, required 5", lat);
        end
        idle();
        n_checks++;
        if (busy !== 1'b0 || refill_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_done: busy=%b rv=%b, required 0 0", busy, refill_valid);
        end
    endtask

    task automatic test_slow_ack();
        int lat;
        ack_period = 3; mem_mode = 0;
        exp_addr.push_back(32'h200C); exp_addr.push_back(32'h2000);
        exp_addr.push_back(32'h2004); exp_addr.push_back(32'h2008);
        exp_raddr.push_back(32'h2000);
        exp_rdata.push_back({32'h200C, 32'h2008, 32'h2004, 32'h2000});
        refill(32'h200C, -1, 0, 0, 0, lat);
        n_checks++;
        if (lat != 13) begin
            n_fail++;
            $display("FAIL slow_latency: refill_valid at cycle %0d, required 13", lat);
        end
        ack_period = 1;
        idle();
    endtask

    task automatic test_store_merge();
        int lat;
        mem_mode = 1;
        exp_addr.push_back(32'h3000); exp_addr.push_back(32'h3004);
        exp_addr.push_back(32'h3008); exp_addr.push_back(32'h300C);
        exp_raddr.push_back(32'h3000);
        exp_rdata.push_back({32'h1111_1111, 32'h1111_CCDD, 32'h1111_1111, 32'h1111_1111});
        refill(32'h3000, 1, 32'h3008, 32'hAABB_CCDD, 4'b0011, lat);
        idle();
        for (int s = 0; s < 2; s++) begin
            exp_addr.push_back(32'h3000); exp_addr.push_back(32'h3004);
            exp_addr.push_back(32'h3008); exp_addr.push_back(32'h300C);
            exp_raddr.push_back(32'h3000);
            exp_rdata.push_back({32'h1111_1111, 32'h1111_1111, 32'h1111_1155, 32'h1111_1111});
            refill(32'h3000, s == 0 ? 5 : 2, 32'h3004, 32'hFFFF_FF55, 4'b0001, lat);
            idle();
        end
        mem_mode = 0;
        exp_addr.push_back(32'h5000); exp_addr.push_back(32'h5004);
        exp_addr.push_back(32'h5008); exp_addr.push_back(32'h500C);
        exp_raddr.push_back(32'h5000);
        exp_rdata.push_back({32'h500C, 32'h5008, 32'h5004, 32'h5000});
        refill(32'h5000, 2, 32'h6008, 32'hAABB_CCDD, 4'b1111, lat);
        idle();
    endtask

    task automatic test_reset_mid();
        int lat;
        ack_period = 1; mem_mode = 0;
        exp_addr.push_back(32'h7004); exp_addr.push_back(32'h7008);
        drive(1'b1, 32'h7004, 1'b0, 4'h0, 32'h0, 32'h0);
        idle();
        idle();
        rst = 1'b0;
        idle();
        rst = 1'b1;
        idle();
        n_checks++;
        if ({mem_req, busy, refill_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid: req=%b busy=%b rv=%b, required 0 0 0", mem_req, busy, refill_valid);
        end
        for (int i = 0; i < 6; i++) idle();
        n_checks++;
        if (exp_addr.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_fetches: %0d expected fetches left, required 0", exp_addr.size());
        end
        exp_addr.push_back(32'h7004); exp_addr.push_back(32'h7008);
        exp_addr.push_back(32'h700C); exp_addr.push_back(32'h7000);
        exp_raddr.push_back(32'h7000);
        exp_rdata.push_back({32'h700C, 32'h7008, 32'h7004, 32'h7000});
        refill(32'h7004, -1, 0, 0, 0, lat);
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL restart_latency: refill_valid at cycle %0d, required 5", lat);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        int v0, c0;
        v0 = valid_count;
        c0 = cyc;
        for (int a = 32'h8000; a <= 32'h800C; a += 4) exp_addr.push_back(a);
        for (int a = 32'h9000; a <= 32'h900C; a += 4) exp_addr.push_back(a);
        exp_raddr.push_back(32'h8000);
        exp_rdata.push_back({32'h800C, 32'h8008, 32'h8004, 32'h8000});
        exp_raddr.push_back(32'h9000);
        exp_rdata.push_back({32'h900C, 32'h9008, 32'h9004, 32'h9000});
        for (int k = 0; k < 12; k++)
            drive(1'b1, k == 0 ? 32'h8000 : 32'h9000, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) idle();
        n_checks++;
        if (valid_count - v0 != 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d refill_valid pulses, required 2", valid_count - v0);
        end
        n_checks++;
        if (last_valid_cyc - c0 != 12) begin
            n_fail++;
            $display("FAIL b2b_timing: second pulse at cycle %0d, required 12", last_valid_cyc - c0);
        end
    endtask

    initial begin
        rst = 1'b0; miss = 1'b0; miss_addr = '0; we = 1'b0; wvalid_bit = '0;
        waddr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_critical_word();
        test_slow_ack();
        test_store_merge();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (exp_addr.size() != 0 || exp_raddr.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d fetches and %0d lines outstanding, required 0 0",
                     exp_addr.size(), exp_raddr.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
